// File: rtl/fpu_lzd_normalizer.sv
// fpu_lzd_normalizer: two-stage leading-zero count and normalize stage for the bfloat16 FPU datapath
// Ports:
//   clk, rst_l                        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready                 upstream handshake; in_ready is combinational from out_ready
//   in_mant, in_exp                   unnormalized mantissa and its biased exponent
//   out_valid/out_ready               downstream handshake to the rounding stage
//   out_mant, out_exp, out_lzc        normalized mantissa, adjusted exponent, raw leading-zero count
//   out_zero, out_underflow           mantissa was zero, exponent clamped to 0
module fpu_lzd_normalizer #(
  parameter int MANT_W = 32,
  parameter int EXP_W  = 8,
  parameter int LZC_W  = 6
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [LZC_W-1:0]  out_lzc,
  output logic              out_zero,
  output logic              out_underflow
);
  logic              s1_valid, s2_valid, s1_adv, s1_zero, lz_zero, norm;
  logic [MANT_W-1:0] s1_mant, n_mant;
  logic [EXP_W-1:0]  s1_exp, dexp, lzc_e, n_exp;
  logic [LZC_W-1:0]  s1_lzc, lzc;
  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = s2_valid;
  // Layered LZD tree: level k holds 16>>k groups of 2^(k+1) bits, each with an
  // all-zero flag z and a leading-zero count c of k+1 bits (valid when !z).
  // A group whose upper half is all zero counts 2^k plus the lower half's count.
  genvar k, j;
  for (k = 0; k < 5; k++) begin : lvl
    localparam int N = 16 >> k;
    logic [N-1:0]      z;
    logic [N-1:0][k:0] c;
    for (j = 0; j < N; j++) begin : g
      if (k == 0) begin : leaf
        assign z[j] = ~(in_mant[2*j+1] | in_mant[2*j]);
        assign c[j] = ~in_mant[2*j+1];
      end else begin : node
        assign z[j] = lvl[k-1].z[2*j+1] & lvl[k-1].z[2*j];
        assign c[j] = lvl[k-1].z[2*j+1] ? {1'b1, lvl[k-1].c[2*j]} : {1'b0, lvl[k-1].c[2*j+1]};
      end
    end
  end
  assign lz_zero = lvl[4].z[0];
  assign lzc     = lz_zero ? LZC_W'(MANT_W) : {1'b0, lvl[4].c[0]};
  // Normal when the shift fits under the exponent; otherwise clamp to exponent 0
  // and shift only by exp-1 so the value keeps its denormal scale.
  assign lzc_e = {{(EXP_W-LZC_W){1'b0}}, s1_lzc};
  assign dexp  = s1_exp - EXP_W'(1);
  assign norm  = lzc_e < s1_exp;
  always_comb begin
    n_mant = s1_zero ? '0 : norm ? s1_mant << s1_lzc : (s1_exp != '0) ? s1_mant << dexp : s1_mant;
    n_exp  = (s1_zero || !norm) ? '0 : s1_exp - lzc_e;
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid      <= 1'b0;
      s1_mant       <= '0;
      s1_exp        <= '0;
      s1_lzc        <= '0;
      s1_zero       <= 1'b0;
      s2_valid      <= 1'b0;
      out_mant      <= '0;
      out_exp       <= '0;
      out_lzc       <= '0;
      out_zero      <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_mant <= in_mant;
        s1_exp  <= in_exp;
        s1_lzc  <= lzc;
        s1_zero <= lz_zero;
      end
      if (s1_adv) s2_valid <= s1_valid;
      if (s1_valid && s1_adv) begin
        out_mant      <= n_mant;
        out_exp       <= n_exp;
        out_lzc       <= s1_lzc;
        out_zero      <= s1_zero;
        out_underflow <= !s1_zero && !norm;
      end
    end
  end
endmodule

// File: tb/tb_fpu_lzd_normalizer.sv
// tb_fpu_lzd_normalizer: directed self-checking bench for fpu_lzd_normalizer
module tb_fpu_lzd_normalizer;
  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_mant = '0;
  logic [7:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_mant;
  logic [7:0]  out_exp;
  logic [5:0]  out_lzc;
  logic        out_zero;
  logic        out_underflow;
  int          errors = 0;
  int          checks = 0;
  fpu_lzd_normalizer dut (
    .clk(clk),
    .rst_l(rst_l),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_mant(in_mant),
    .in_exp(in_exp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mant(out_mant),
    .out_exp(out_exp),
    .out_lzc(out_lzc),
    .out_zero(out_zero),
    .out_underflow(out_underflow)
  );
  always #5 clk = ~clk;
  wire [47:0] res = {out_mant, out_exp, out_lzc, out_zero, out_underflow};
  // Sends one item into an empty pipeline with out_ready=1 and waits for its
  // result; lat counts edges after the accepting edge (0 means it never came).
  task automatic run_one(input logic [31:0] m, input logic [7:0] e, output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mant   = m;
    in_exp    = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat = i;
    end
    if (lat == 0) begin
      errors++;
      $display("FAIL run_one_timeout: no out_valid for mant %h exp %0d within 10 cycles", m, e);
    end
  endtask
  task automatic test_reset;
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, res} !== 49'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {out_valid, res});
    end
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: in_ready/out_valid got %b expected 10", {in_ready, out_valid});
    end
  endtask
  task automatic test_normal;
    int lat;
    run_one(32'h0000F000, 8'd128, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL latency: got %0d extra edges expected 1", lat);
    end
    checks++;
    if (res !== {32'hF0000000, 8'd112, 6'd16, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL normal_f000: got %h expected %h", res, {32'hF0000000, 8'd112, 6'd16, 1'b0, 1'b0});
    end
    run_one(32'h80000000, 8'd5, lat);
    checks++;
    if (res !== {32'h80000000, 8'd5, 6'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL already_normal: got %h expected %h", res, {32'h80000000, 8'd5, 6'd0, 1'b0, 1'b0});
    end
    run_one(32'h00000000, 8'd77, lat);
    checks++;
    if (res !== {32'h0, 8'd0, 6'd32, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL zero: got %h expected %h", res, {32'h0, 8'd0, 6'd32, 1'b1, 1'b0});
    end
  endtask
  task automatic test_denormal;
    int lat;
    run_one(32'h00000001, 8'd10, lat);
    checks++;
    if (res !== {32'h00000200, 8'd0, 6'd31, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL denorm_clamp: got %h expected %h", res, {32'h00000200, 8'd0, 6'd31, 1'b0, 1'b1});
    end
    run_one(32'h00F00000, 8'd0, lat);
    checks++;
    if (res !== {32'h00F00000, 8'd0, 6'd8, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL exp_zero: got %h expected %h", res, {32'h00F00000, 8'd0, 6'd8, 1'b0, 1'b1});
    end
  endtask
  task automatic test_boundary;
    int lat;
    run_one(32'h00800000, 8'd9, lat);
    checks++;
    if (res !== {32'h80000000, 8'd1, 6'd8, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL lzc_eq_exp_m1: got %h expected %h", res, {32'h80000000, 8'd1, 6'd8, 1'b0, 1'b0});
    end
    run_one(32'h00800000, 8'd8, lat);
    checks++;
    if (res !== {32'h40000000, 8'd0, 6'd8, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL lzc_eq_exp: got %h expected %h", res, {32'h40000000, 8'd0, 6'd8, 1'b0, 1'b1});
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] m [3] = '{32'h40000000, 32'h00000100, 32'h0000000F};
    logic [7:0]  e [3] = '{8'd3, 8'd255, 8'd20};
    logic [48:0] x [3] = '{{1'b1, 32'h80000000, 8'd2, 6'd1, 1'b0, 1'b0},
                           {1'b1, 32'h80000000, 8'd232, 6'd23, 1'b0, 1'b0},
                           {1'b1, 32'h00780000, 8'd0, 6'd28, 1'b0, 1'b1}};
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = c < 3;
      if (c < 3) begin
        in_mant = m[c];
        in_exp  = e[c];
      end
      @(negedge clk);
      if (c >= 2) begin
        checks++;
        if ({out_valid, res} !== x[c-2]) begin
          errors++;
          $display("FAIL back_to_back[%0d]: got %h expected %h", c - 2, {out_valid, res}, x[c-2]);
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask
  task automatic test_backpressure;
    logic [31:0] m [4] = '{32'h00010000, 32'h12345678, 32'h00000003, 32'h0000ABCD};
    logic [7:0]  e [4] = '{8'd100, 8'd50, 8'd40, 8'd200};
    logic [47:0] x [4] = '{{32'h80000000, 8'd85, 6'd15, 1'b0, 1'b0},
                           {32'h91A2B3C0, 8'd47, 6'd3, 1'b0, 1'b0},
                           {32'hC0000000, 8'd10, 6'd30, 1'b0, 1'b0},
                           {32'hABCD0000, 8'd184, 6'd16, 1'b0, 1'b0}};
    int k = 0;
    int got = 0;
    int last = -1;
    logic xin;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mant   = m[0];
    in_exp    = e[0];
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (c == 4) out_ready = 1'b1;
      @(negedge clk);
      if (c == 2 || c == 3) begin
        checks++;
        if ({in_ready, out_valid, res} !== {2'b01, x[0]}) begin
          errors++;
          $display("FAIL stall_hold[%0d]: got %h expected %h", c, {in_ready, out_valid, res}, {2'b01, x[0]});
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (res !== x[got]) begin
          errors++;
          $display("FAIL drain_order[%0d]: got %h expected %h", got, res, x[got]);
        end
        got++;
        last = c;
      end
      xin = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (xin) begin
        k++;
        in_valid = k < 4;
        if (k < 4) begin
          in_mant = m[k];
          in_exp  = e[k];
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 4 || last !== 7) begin
      errors++;
      $display("FAIL drain_count: got %0d results ending cycle %0d expected 4 ending cycle 7", got, last);
    end
  endtask
  task automatic test_reset_midflight;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mant   = 32'h00001234;
    in_exp    = 8'd60;
    @(posedge clk);
    #1;
    in_mant = 32'h00000055;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b01) begin
      errors++;
      $display("FAIL midflight_full: in_ready/out_valid got %b expected 01", {in_ready, out_valid});
    end
    rst_l = 1'b0;
    #1;
    checks++;
    if ({out_valid, res} !== 49'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", {out_valid, res});
    end
    @(negedge clk);
    rst_l = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        errors++;
        $display("FAIL no_stale[%0d]: in_ready/out_valid got %b expected 10", c, {in_ready, out_valid});
      end
    end
  endtask
  initial begin
    test_reset;
    test_normal;
    test_denormal;
    test_boundary;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
